// File: rtl/ip_hdr_chksum_gen.sv
// IPv4 header builder and checksum engine: assembles (generate) or checks (verify) a
// 20-60 byte header, summing LANES 16-bit words per clock with a double end-around-carry fold.
module ip_hdr_chksum_gen #(
    parameter int          LANES         = 1,
    parameter int          MAX_OPT_WORDS = 1,
    parameter logic [7:0]  IP_TTL        = 8'h80,
    parameter logic        IP_DF         = 1'b1,
    parameter logic [15:0] ID_INIT       = 16'h0000
) (
    input  logic                            ip_tx_clk,
    input  logic                            reset_n,
    input  logic                            ip_hdr_req,
    input  logic                            chk_mode,
    input  logic [15:0]                     ip_total_len,
    input  logic [7:0]                      IpPro,
    input  logic [31:0]                     IpSrcIP,
    input  logic [31:0]                     IpDstIP,
    input  logic [3:0]                      ip_opt_words,
    input  logic [32*MAX_OPT_WORDS-1:0]     ip_opt_data,
    input  logic [15:0]                     id_in,
    input  logic [15:0]                     chk_in,
    output logic                            ip_hdr_done,
    output logic [160+32*MAX_OPT_WORDS-1:0] ip_tx_header,
    output logic [15:0]                     ip_chksum,
    output logic                            chk_ok,
    output logic                            busy
);
    localparam int         HW      = 160 + 32*MAX_OPT_WORDS;
    localparam int         OW      = 32*MAX_OPT_WORDS;
    localparam int         LW      = 16*LANES;
    localparam int         CKPOS   = HW - 1 - 80;
    localparam logic [3:0] MAX_OPT = 4'(MAX_OPT_WORDS);

    typedef enum logic [2:0] {IDLE, LOAD, SUM, FOLD1, FOLD2, DONE} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hdr_q, hdr_d;
    logic [HW-1:0] shift_q, shift_d;
    logic [HW-1:0] out_q, out_d;
    logic [20:0]   acc_q, acc_d;
    logic [16:0]   s1_q, s1_d;
    logic [15:0]   id_q, id_d;
    logic [15:0]   chk_q, chk_d;
    logic          ok_q, ok_d;
    logic          mode_q, mode_d;
    logic [4:0]    cnt_q, cnt_d;

    logic [3:0]    opt;
    logic [4:0]    nwords;
    logic [5:0]    cycTmp;
    logic [4:0]    ncycles;
    logic [OW-1:0] optMask;
    logic [HW-1:0] hdrNew;
    logic [20:0]   laneSum;
    logic [15:0]   s2;

    // Header image as it enters the summing shift register; unused option words are masked off.
    always_comb begin
        opt     = (ip_opt_words > MAX_OPT) ? MAX_OPT : ip_opt_words;
        nwords  = 5'd10 + {opt, 1'b0};
        cycTmp  = 6'(nwords) + 6'(LANES - 1);
        ncycles = 5'(cycTmp / 6'(LANES));
        optMask = ~({OW{1'b1}} >> {opt, 5'b0});
        hdrNew  = {4'h4, 4'd5 + opt, 8'h00,
                   ip_total_len,
                   chk_mode ? id_in : id_q,
                   {1'b0, IP_DF, 14'h0},
                   IP_TTL, IpPro,
                   chk_mode ? chk_in : 16'h0000,
                   IpSrcIP, IpDstIP,
                   ip_opt_data & optMask};
    end

    always_comb begin
        laneSum = '0;
        for (int i = 0; i < LANES; i++) begin
            laneSum = laneSum + 21'(shift_q[HW-1-16*i -: 16]);
        end
    end

    assign s2 = s1_q[15:0] + 16'(s1_q[16]);

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        shift_d = shift_q;
        out_d   = out_q;
        acc_d   = acc_q;
        s1_d    = s1_q;
        id_d    = id_q;
        chk_d   = chk_q;
        ok_d    = ok_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (ip_hdr_req) state_d = LOAD;
            end
            LOAD: begin
                hdr_d   = hdrNew;
                shift_d = hdrNew;
                acc_d   = '0;
                mode_d  = chk_mode;
                cnt_d   = ncycles;
                state_d = SUM;
            end
            SUM: begin
                acc_d   = acc_q + laneSum;
                shift_d = shift_q << LW;
                cnt_d   = cnt_q - 5'd1;
                if (cnt_q == 5'd1) state_d = FOLD1;
            end
            FOLD1: begin
                s1_d    = 17'(acc_q[15:0]) + 17'(acc_q[20:16]);
                state_d = FOLD2;
            end
            FOLD2: begin
                chk_d = ~s2;
                ok_d  = mode_q & (s2 == 16'hFFFF);
                out_d = hdr_q;
                // Verify mode leaves the received checksum in the header untouched.
                if (!mode_q) begin
                    out_d[CKPOS -: 16] = ~s2;
                    id_d               = id_q + 16'd1;
                end
                state_d = DONE;
            end
            DONE: begin
                if (!ip_hdr_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ip_tx_clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hdr_q   <= '0;
            shift_q <= '0;
            out_q   <= '0;
            acc_q   <= '0;
            s1_q    <= '0;
            id_q    <= ID_INIT;
            chk_q   <= '0;
            ok_q    <= 1'b0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            acc_q   <= acc_d;
            s1_q    <= s1_d;
            id_q    <= id_d;
            chk_q   <= chk_d;
            ok_q    <= ok_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ip_hdr_done  = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign ip_tx_header = out_q;
    assign ip_chksum    = chk_q;
    assign chk_ok       = ok_q;

endmodule

// File: tb/tb_ip_hdr_chksum_gen.sv
// Bench for ip_hdr_chksum_gen: three instances (LANES 1/2/4) checked against a
// one's-complement reference model through an expected-result queue.
module tb_ip_hdr_chksum_gen;
    localparam int MAXO = 10;
    localparam int HW   = 160 + 32*MAXO;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset_n;
    logic [2:0]          reqv;
    logic                chkMode;
    logic [15:0]         totalLen;
    logic [7:0]          pro;
    logic [31:0]         src, dst;
    logic [3:0]          optW;
    logic [32*MAXO-1:0]  optD;
    logic [15:0]         idIn, chkIn;

    logic                doneW [3];
    logic [HW-1:0]       hdrW  [3];
    logic [15:0]         sumW  [3];
    logic                okW   [3];
    logic                busyW [3];

    ip_hdr_chksum_gen #(.LANES(1), .MAX_OPT_WORDS(MAXO), .IP_TTL(8'h40), .IP_DF(1'b1), .ID_INIT(16'h0000)) u0 (
        .ip_tx_clk(clk), .reset_n(reset_n), .ip_hdr_req(reqv[0]), .chk_mode(chkMode),
        .ip_total_len(totalLen), .IpPro(pro), .IpSrcIP(src), .IpDstIP(dst),
        .ip_opt_words(optW), .ip_opt_data(optD), .id_in(idIn), .chk_in(chkIn),
        .ip_hdr_done(doneW[0]), .ip_tx_header(hdrW[0]), .ip_chksum(sumW[0]), .chk_ok(okW[0]), .busy(busyW[0]));

    ip_hdr_chksum_gen #(.LANES(2), .MAX_OPT_WORDS(MAXO), .IP_TTL(8'h40), .IP_DF(1'b1), .ID_INIT(16'hFFFF)) u1 (
        .ip_tx_clk(clk), .reset_n(reset_n), .ip_hdr_req(reqv[1]), .chk_mode(chkMode),
        .ip_total_len(totalLen), .IpPro(pro), .IpSrcIP(src), .IpDstIP(dst),
        .ip_opt_words(optW), .ip_opt_data(optD), .id_in(idIn), .chk_in(chkIn),
        .ip_hdr_done(doneW[1]), .ip_tx_header(hdrW[1]), .ip_chksum(sumW[1]), .chk_ok(okW[1]), .busy(busyW[1]));

    ip_hdr_chksum_gen #(.LANES(4), .MAX_OPT_WORDS(MAXO), .IP_TTL(8'h40), .IP_DF(1'b1), .ID_INIT(16'h0000)) u2 (
        .ip_tx_clk(clk), .reset_n(reset_n), .ip_hdr_req(reqv[2]), .chk_mode(chkMode),
        .ip_total_len(totalLen), .IpPro(pro), .IpSrcIP(src), .IpDstIP(dst),
        .ip_opt_words(optW), .ip_opt_data(optD), .id_in(idIn), .chk_in(chkIn),
        .ip_hdr_done(doneW[2]), .ip_tx_header(hdrW[2]), .ip_chksum(sumW[2]), .chk_ok(okW[2]), .busy(busyW[2]));

    typedef struct {
        logic [15:0]   chksum;
        logic          ok;
        logic [HW-1:0] hdr;
        int            lat;
    } exp_t;

    exp_t          sbq[$];
    logic [15:0]   expId [3];
    logic [15:0]   lastSum;
    logic [HW-1:0] lastHdr;
    int            checks = 0;
    int            errors = 0;

    task automatic checkOutput(input string tag, input logic [HW-1:0] act, input logic [HW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int lanesOf(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 4;
    endfunction

    // Reference header image built straight from the field list.
    function automatic logic [HW-1:0] buildHdr(input logic [15:0] id, input logic [15:0] ck, input int opt);
        logic [HW-1:0] h;
        h = '0;
        h[HW-1 -: 160] = {4'h4, 4'(5 + opt), 8'h00, totalLen, id, 16'h4000, 8'h40, pro, ck, src, dst};
        for (int i = 0; i < opt; i++) h[HW-161-32*i -: 32] = optD[32*MAXO-1-32*i -: 32];
        return h;
    endfunction

    function automatic logic [15:0] onesSum(input logic [HW-1:0] h);
        int unsigned s;
        s = 0;
        for (int i = 0; i < HW/16; i++) s += 32'(h[HW-1-16*i -: 16]);
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        return s[15:0];
    endfunction

    // Runs one transaction on instance k; dropAfter>0 releases req that many cycles in.
    task automatic applyStimulus(input int k, input logic mode, input logic [3:0] ow,
                                 input int dropAfter, input int holdExtra);
        exp_t          e;
        exp_t          got;
        int            opt;
        int            n;
        int            cycles;
        logic [15:0]   id;
        logic [15:0]   s;
        logic [HW-1:0] h0;
        opt = (ow > 4'd10) ? 10 : int'(ow);
        n   = 10 + 2*opt;
        id  = mode ? idIn : expId[k];
        h0  = buildHdr(id, mode ? chkIn : 16'h0000, opt);
        s   = onesSum(h0);
        e.chksum = ~s;
        e.ok     = mode && (s == 16'hFFFF);
        e.hdr    = h0;
        if (!mode) e.hdr[HW-81 -: 16] = ~s;
        e.lat    = (n + lanesOf(k) - 1) / lanesOf(k) + 3;
        sbq.push_back(e);

        @(negedge clk);
        optW    = ow;
        chkMode = mode;
        reqv[k] = 1'b1;
        @(posedge clk);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
            if (dropAfter > 0 && cycles == dropAfter) reqv[k] = 1'b0;
        end while (!doneW[k] && cycles < 100);

        got = sbq.pop_front();
        if (!doneW[k]) begin
            checkOutput("doneTimeout", 0, 1);
            reqv[k] = 1'b0;
            return;
        end
        lastSum = sumW[k];
        lastHdr = hdrW[k];
        checkOutput($sformatf("latency%0d", k), cycles, got.lat);
        checkOutput($sformatf("chksum%0d", k), sumW[k], got.chksum);
        checkOutput($sformatf("chkOk%0d", k), okW[k], got.ok);
        checkOutput($sformatf("header%0d", k), hdrW[k], got.hdr);
        if (!mode) expId[k] = expId[k] + 16'd1;

        if (dropAfter > 0) begin
            @(posedge clk);
            #1;
            checkOutput("donePulse", doneW[k], 0);
        end else begin
            if (holdExtra > 0) begin
                repeat (holdExtra) @(posedge clk);
                #1;
                checkOutput("doneHeld", doneW[k], 1);
            end
            @(negedge clk);
            reqv[k] = 1'b0;
            @(posedge clk);
            #1;
            checkOutput("doneFall", doneW[k], 0);
            checkOutput("busyFall", busyW[k], 0);
            checkOutput("chkStable", sumW[k], got.chksum);
        end
    endtask

    task automatic setTp1Fields();
        totalLen = 16'h0073;
        pro      = 8'h11;
        src      = 32'hC0A80001;
        dst      = 32'hC0A800C7;
        optD     = '0;
        idIn     = 16'h0000;
        chkIn    = 16'h0000;
    endtask

    task automatic randomFields();
        totalLen = 16'($urandom);
        pro      = 8'($urandom);
        src      = $urandom;
        dst      = $urandom;
        for (int i = 0; i < MAXO; i++) optD[32*i +: 32] = $urandom;
    endtask

    initial begin
        int optList [4];
        optList = '{0, 1, 5, 10};
        reset_n = 1'b0;
        reqv    = '0;
        chkMode = 1'b0;
        optW    = '0;
        setTp1Fields();
        expId[0] = 16'h0000;
        expId[1] = 16'hFFFF;
        expId[2] = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput("rstDone", doneW[k], 0);
            checkOutput("rstBusy", busyW[k], 0);
            checkOutput("rstSum", sumW[k], 0);
            checkOutput("rstHdr", hdrW[k], 0);
        end
        @(negedge clk);
        reset_n = 1'b1;

        applyStimulus(0, 1'b0, 4'd0, 0, 2);
        checkOutput("tp1Sum", lastSum, 16'hB861);
        checkOutput("tp1Word5", lastHdr[HW-81 -: 16], 16'hB861);
        applyStimulus(0, 1'b0, 4'd0, 0, 0);
        checkOutput("tp2Sum", lastSum, 16'hB860);
        checkOutput("tp2Id", lastHdr[HW-33 -: 16], 16'h0001);

        chkIn = 16'hB861;
        applyStimulus(0, 1'b1, 4'd0, 0, 0);
        checkOutput("vfyGoodSum", lastSum, 16'h0000);
        chkIn = 16'hB862;
        applyStimulus(0, 1'b1, 4'd0, 0, 0);
        checkOutput("vfyBadOk", okW[0], 0);
        chkIn = 16'h0000;
        applyStimulus(0, 1'b0, 4'd0, 0, 0);
        checkOutput("idAfterVfy", lastHdr[HW-33 -: 16], 16'h0002);

        applyStimulus(1, 1'b0, 4'd0, 0, 0);
        checkOutput("idInitFFFF", lastHdr[HW-33 -: 16], 16'hFFFF);
        applyStimulus(1, 1'b0, 4'd0, 0, 0);
        checkOutput("idWrap", lastHdr[HW-33 -: 16], 16'h0000);

        totalLen = 16'hFFFF;
        pro      = 8'hFF;
        src      = 32'hFFFFFFFF;
        dst      = 32'hFFFFFFFF;
        optD     = '1;
        applyStimulus(2, 1'b0, 4'd10, 0, 0);
        applyStimulus(2, 1'b0, 4'd15, 0, 0);

        setTp1Fields();
        applyStimulus(0, 1'b0, 4'd0, 3, 0);

        // Reset mid-SUM must abort with every output cleared and no ID advance.
        @(negedge clk);
        optW    = 4'd0;
        chkMode = 1'b0;
        reqv[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("busyInSum", busyW[0], 1);
        @(negedge clk);
        reset_n = 1'b0;
        reqv[0] = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abortDone", doneW[0], 0);
        checkOutput("abortBusy", busyW[0], 0);
        checkOutput("abortSum", sumW[0], 0);
        checkOutput("abortOk", okW[0], 0);
        checkOutput("abortHdr", hdrW[0], 0);
        @(negedge clk);
        reset_n = 1'b1;
        expId[0] = 16'h0000;
        expId[1] = 16'hFFFF;
        expId[2] = 16'h0000;
        applyStimulus(0, 1'b0, 4'd0, 0, 0);
        checkOutput("idAfterAbort", lastHdr[HW-33 -: 16], 16'h0000);

        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) begin
                randomFields();
                applyStimulus(k, 1'b0, 4'(optList[j]), 0, 0);
            end
        end

        randomFields();
        idIn  = 16'($urandom);
        chkIn = 16'($urandom);
        applyStimulus(2, 1'b1, 4'd5, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
